// File: rtl/clock_div_pkg.sv
// Shared constants for the programmable clock divider: the board oscillator
// rate and a helper that turns a target frequency into a divisor.
package clock_div_pkg;

    localparam int unsigned CLK_HZ = 100000000;

    function automatic int unsigned div_for_hz(input int unsigned f);
        return CLK_HZ / f;
    endfunction

    localparam int unsigned DEFAULT_DIV = div_for_hz(1);

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: free-running counter, active/shadow divisor pair, and
// registered square-wave and tick outputs.
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 30,
    parameter int unsigned DEFAULT_DIV = clock_div_pkg::DEFAULT_DIV
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pend_o
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic             w_run;
    logic             w_wrap;
    logic             w_apply;
    logic [WIDTH-1:0] w_next_div;

    assign w_run      = en && !sync && (r_div != '0);
    assign w_wrap     = w_run && (r_cnt >= r_div - WIDTH'(1));
    // Divisor swaps only happen at count 0 or at the wrap, so no runt periods.
    assign w_apply    = !w_run || w_wrap;
    assign w_next_div = we ? din : r_shadow;

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_div    <= WIDTH'(DEFAULT_DIV);
            r_shadow <= WIDTH'(DEFAULT_DIV);
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            if (we)
                r_shadow <= din;

            if (w_apply) begin
                r_div  <= w_next_div;
                r_pend <= 1'b0;
            end else if (we) begin
                r_pend <= 1'b1;
            end

            if (w_run) begin
                r_clk  <= (r_cnt < (r_div >> 1));
                r_tick <= w_wrap;
                r_cnt  <= w_wrap ? '0 : r_cnt + WIDTH'(1);
            end else begin
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                r_cnt  <= '0;
            end
        end
    end

    assign clk_o  = r_clk;
    assign tick_o = r_tick;
    assign pend_o = r_pend;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider: decodes divisor writes to one
// channel and runs NUM_CH independent, sync-alignable dividers.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int          NUM_CH      = 3,
    parameter int unsigned WIDTH       = 30,
    parameter int unsigned DEFAULT_DIV = clock_div_pkg::DEFAULT_DIV,
    parameter int          CH_W        = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [WIDTH-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] pend_o
);

    logic [NUM_CH-1:0] w_we;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            // Out-of-range channel numbers match no channel and are dropped.
            assign w_we[c] = cfg_we_i && (cfg_ch_i == CH_W'(c));

            clock_div_channel #(
                .WIDTH       (WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk_i  (clk_i),
                .reset  (reset),
                .en     (en_i[c]),
                .sync   (sync_i),
                .we     (w_we[c]),
                .din    (cfg_div_i),
                .clk_o  (clk_o[c]),
                .tick_o (tick_o[c]),
                .pend_o (pend_o[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench for clock_div_prog: a behavioural model predicts each
// cycle's outputs, which are queued and compared after the clock edge.
module tb_clock_div_prog;

    logic       clk_i     = 1'b0;
    logic       reset     = 1'b0;
    logic [2:0] en_i      = '0;
    logic       sync_i    = 1'b0;
    logic       cfg_we_i  = 1'b0;
    logic [1:0] cfg_ch_i  = '0;
    logic [7:0] cfg_div_i = '0;
    logic [2:0] clk_o;
    logic [2:0] tick_o;
    logic [2:0] pend_o;

    typedef struct packed {
        logic [2:0] clk;
        logic [2:0] tick;
        logic [2:0] pend;
    } exp_t;

    exp_t sb[$];
    int   m_cnt[3];
    int   m_div[3];
    int   m_sh[3];
    bit   m_pend[3];
    int   n_asrt = 0;
    int   n_fail = 0;

    clock_div_prog #(
        .NUM_CH      (3),
        .WIDTH       (8),
        .DEFAULT_DIV (6)
    ) dut (
        .clk_i     (clk_i),
        .reset     (reset),
        .en_i      (en_i),
        .sync_i    (sync_i),
        .cfg_we_i  (cfg_we_i),
        .cfg_ch_i  (cfg_ch_i),
        .cfg_div_i (cfg_div_i),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .pend_o    (pend_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < 3; c++) begin
            m_cnt[c]  = 0;
            m_div[c]  = 6;
            m_sh[c]   = 6;
            m_pend[c] = 1'b0;
        end
    endfunction

    // Next-edge outputs from the current model state and driven inputs.
    function automatic exp_t m_step();
        exp_t e;
        bit   we, run, wrap;
        e = '0;
        for (int c = 0; c < 3; c++) begin
            we   = cfg_we_i && (int'(cfg_ch_i) == c);
            run  = en_i[c] && !sync_i && (m_div[c] != 0);
            wrap = run && (m_cnt[c] >= m_div[c] - 1);
            e.clk[c]  = run && (m_cnt[c] < m_div[c] / 2);
            e.tick[c] = wrap;
            m_cnt[c]  = (run && !wrap) ? m_cnt[c] + 1 : 0;
            if (!run || wrap) begin
                m_div[c]  = we ? int'(cfg_div_i) : m_sh[c];
                m_pend[c] = 1'b0;
            end else if (we) begin
                m_pend[c] = 1'b1;
            end
            if (we)
                m_sh[c] = int'(cfg_div_i);
            e.pend[c] = m_pend[c];
        end
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        sb.push_back(m_step());
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        check("sb.clk",  clk_o,  e.clk);
        check("sb.tick", tick_o, e.tick);
        check("sb.pend", pend_o, e.pend);
    endtask

    task automatic wr(input int ch, input int n);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'(ch);
        cfg_div_i = 8'(n);
        cyc();
        cfg_we_i  = 1'b0;
    endtask

    initial begin
        int guard;
        m_reset();
        #3;
        check("rst.clk",  clk_o,  0);
        check("rst.tick", tick_o, 0);
        check("rst.pend", pend_o, 0);
        @(negedge clk_i);
        reset = 1'b1;
        en_i  = 3'b111;

        // default N=6 pattern on every channel
        for (int i = 1; i <= 18; i++) begin
            cyc();
            check("t1.clk",  clk_o,  (((i - 1) % 6) < 3) ? 7 : 0);
            check("t1.tick", tick_o, (i % 6 == 0) ? 7 : 0);
        end

        // ch0 -> N=4 written at count 2, pending until the 6-cycle wrap
        repeat (2) cyc();
        wr(0, 4);
        check("t2.pend1", pend_o[0], 1);
        repeat (2) cyc();
        check("t2.pend2", pend_o[0], 1);
        cyc();
        check("t2.apply", pend_o[0], 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("t2.clk0", clk_o[0], ((i % 4) < 2) ? 1 : 0);
        end

        // ch1: N=5, then N=1, then N=0, then recovery write while stopped
        wr(1, 5);
        repeat (14) cyc();
        wr(1, 1);
        repeat (8) cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t3.n1tick", tick_o[1], 1);
            check("t3.n1clk",  clk_o[1],  0);
        end
        wr(1, 0);
        check("t3.n0pend", pend_o[1], 0);
        cyc();
        check("t3.n0tick", tick_o[1], 0);
        check("t3.n0clk",  clk_o[1],  0);
        wr(1, 4);
        check("t3.stopwr", pend_o[1], 0);
        repeat (3) cyc();

        // re-program at arbitrary phases, then align with sync
        wr(0, 6);
        repeat (3) cyc();
        wr(1, 4);
        repeat (5) cyc();
        sync_i = 1'b1;
        cyc();
        sync_i = 1'b0;
        check("t4.syncclk",  clk_o,  0);
        check("t4.synctick", tick_o, 0);
        for (int i = 1; i <= 24; i++) begin
            cyc();
            if (i % 12 == 0)
                check("t4.coinc", tick_o[1:0], 3);
        end

        // async reset with a write pending on ch2
        wr(2, 3);
        check("t5.pend", pend_o[2], 1);
        #3;
        reset = 1'b0;
        #1;
        check("t5.aclk",  clk_o,  0);
        check("t5.atick", tick_o, 0);
        check("t5.apend", pend_o, 0);
        @(posedge clk_i);
        #1;
        check("t5.hold", {clk_o, tick_o, pend_o}, 0);
        reset = 1'b1;
        m_reset();
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check("t5.clk",  clk_o,  (((i - 1) % 6) < 3) ? 7 : 0);
            check("t5.pend", pend_o, 0);
        end

        // out-of-range channel write is ignored
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd3;
        cfg_div_i = 8'd2;
        cyc();
        cfg_we_i  = 1'b0;
        check("t6.oor", pend_o, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check("t6.tick", tick_o, (i % 6 == 5) ? 7 : 0);
        end

        // write landing exactly on a wrap edge never raises pend
        guard = 0;
        while (m_cnt[2] != m_div[2] - 1 && guard < 20) begin
            cyc();
            guard++;
        end
        check("t6.bound", (guard < 20) ? 1 : 0, 1);
        wr(2, 4);
        check("t6.wrap", pend_o[2], 0);
        repeat (8) cyc();

        // disable/re-enable ch2 restarts at phase 0
        en_i[2] = 1'b0;
        repeat (3) cyc();
        check("t6.off", {clk_o[2], tick_o[2]}, 0);
        en_i[2] = 1'b1;
        cyc();
        check("t6.restart", clk_o[2], 1);
        repeat (8) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
